// File: rtl/msp430_bb_pkg.sv
// Shared types for the Blackbone external responder: request record, tag and word-offset helper.
package msp430_bb_pkg;

  localparam int BB_AW = 32;
  localparam int BB_DW = 32;

  typedef enum logic {
    BB_TAG_BUS = 1'b0,
    BB_TAG_BD  = 1'b1
  } bb_tag_e;

  // Request fields are sized for the 32-bit Blackbone port.
  typedef struct packed {
    logic [BB_AW-1:0] addr;
    logic [BB_DW-1:0] data;
    logic             we;
    bb_tag_e          tag;
  } bb_req_t;

  function automatic int bb_word_lsb(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/msp430_bb_ext_responder_if.sv
// Bus, backdoor and error-status signals of the external responder.
interface msp430_bb_ext_responder_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [AW-1:0] bb_ext_addr_i;
  logic [DW-1:0] bb_ext_din_i;
  logic          bb_ext_en_i;
  logic          bb_ext_we_i;
  logic [DW-1:0] bb_ext_dout_o;

  logic          bd_valid;
  logic          bd_ready;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_wdata;
  logic          bd_rvalid;
  logic [DW-1:0] bd_rdata;

  logic [15:0]   err_count;
  logic [AW-1:0] err_addr;

  modport master (
    output bb_ext_addr_i, bb_ext_din_i, bb_ext_en_i, bb_ext_we_i,
    input  bb_ext_dout_o,
    output bd_valid, bd_we, bd_addr, bd_wdata,
    input  bd_ready, bd_rvalid, bd_rdata,
    input  err_count, err_addr
  );

  modport slave (
    input  bb_ext_addr_i, bb_ext_din_i, bb_ext_en_i, bb_ext_we_i,
    output bb_ext_dout_o,
    input  bd_valid, bd_we, bd_addr, bd_wdata,
    output bd_ready, bd_rvalid, bd_rdata,
    output err_count, err_addr
  );

endinterface

// File: rtl/msp430_bb_rdpipe.sv
// LATENCY-deep read pipeline: stage 0 registers RAM read data, later stages delay it with its tag.
module msp430_bb_rdpipe
  import msp430_bb_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  bb_tag_e       i_tag,
  input  logic          i_in_win,
  input  logic [DW-1:0] i_rdata,
  output logic          o_valid,
  output bb_tag_e       o_tag,
  output logic          o_in_win,
  output logic [DW-1:0] o_rdata
);

  logic          r_valid  [LATENCY];
  bb_tag_e       r_tag    [LATENCY];
  logic          r_in_win [LATENCY];
  logic [DW-1:0] r_data   [LATENCY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= BB_TAG_BUS;
        r_in_win[i] <= 1'b0;
      end
    end else begin
      r_valid[0]  <= i_valid;
      r_tag[0]    <= i_tag;
      r_in_win[0] <= i_in_win;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i]  <= r_valid[i-1];
        r_tag[i]    <= r_tag[i-1];
        r_in_win[i] <= r_in_win[i-1];
      end
    end
  end

  // Data is only consumed when the matching valid bit is set, so it needs no reset.
  always_ff @(posedge clk) begin
    r_data[0] <= i_rdata;
    for (int i = 1; i < LATENCY; i++) begin
      r_data[i] <= r_data[i-1];
    end
  end

  assign o_valid  = r_valid[LATENCY-1];
  assign o_tag    = r_tag[LATENCY-1];
  assign o_in_win = r_in_win[LATENCY-1];
  assign o_rdata  = r_data[LATENCY-1];

endmodule

// File: rtl/msp430_bb_ext_responder.sv
// Responder for a tile's external Blackbone port: memory window, backdoor port, error capture.
module msp430_bb_ext_responder
  import msp430_bb_pkg::*;
#(
  parameter int            AW      = 32,
  parameter int            DW      = 32,
  parameter int            DEPTH   = 4096,
  parameter logic [AW-1:0] BASE    = '0,
  parameter int            LATENCY = 1
) (
  input logic                       clk,
  input logic                       rst,
  msp430_bb_ext_responder_if.slave  bb
);

  localparam int            LSB       = bb_word_lsb(DW);
  localparam int            IW        = $clog2(DEPTH);
  localparam logic [AW:0]   WIN_BYTES = (AW+1)'(DEPTH * (DW / 8));

  bb_req_t       w_req;
  logic          w_bd_go;
  logic          w_acc;
  logic          w_rd_go;
  logic [AW-1:0] w_off;
  logic          w_in_win;
  logic [IW-1:0] w_idx;
  logic [DW-1:0] w_ram_rd;

  logic          w_p_valid;
  bb_tag_e       w_p_tag;
  logic          w_p_in_win;
  logic [DW-1:0] w_p_rdata;
  logic [DW-1:0] w_p_data;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_dout;
  logic [DW-1:0] r_bd_rdata;
  logic          r_bd_rvalid;
  logic [15:0]   r_err_count;
  logic [AW-1:0] r_err_addr;

  // The bus never stalls; the backdoor only gets idle bus cycles.
  assign bb.bd_ready = !bb.bb_ext_en_i;
  assign w_bd_go     = bb.bd_valid && !bb.bb_ext_en_i;
  assign w_acc       = bb.bb_ext_en_i || w_bd_go;

  always_comb begin
    w_req = '{addr: bb.bb_ext_addr_i, data: bb.bb_ext_din_i,
              we: bb.bb_ext_we_i, tag: BB_TAG_BUS};
    if (!bb.bb_ext_en_i) begin
      w_req = '{addr: bb.bd_addr, data: bb.bd_wdata,
                we: bb.bd_we, tag: BB_TAG_BD};
    end
  end

  // Unsigned offset makes addresses below BASE wrap to huge values, i.e. out of window.
  assign w_off    = w_req.addr - BASE;
  assign w_in_win = {1'b0, w_off} < WIN_BYTES;
  assign w_idx    = w_req.addr[LSB +: IW];
  assign w_rd_go  = w_acc && !w_req.we;

  always_ff @(posedge clk) begin
    if (w_acc && w_req.we && w_in_win) begin
      r_mem[w_idx] <= w_req.data;
    end
  end

  assign w_ram_rd = r_mem[w_idx];

  msp430_bb_rdpipe #(
    .LATENCY (LATENCY),
    .DW      (DW)
  ) u_rdpipe (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (w_rd_go),
    .i_tag    (w_req.tag),
    .i_in_win (w_in_win),
    .i_rdata  (w_ram_rd),
    .o_valid  (w_p_valid),
    .o_tag    (w_p_tag),
    .o_in_win (w_p_in_win),
    .o_rdata  (w_p_rdata)
  );

  assign w_p_data = w_p_in_win ? w_p_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout      <= '0;
      r_bd_rdata  <= '0;
      r_bd_rvalid <= 1'b0;
    end else begin
      r_bd_rvalid <= w_p_valid && (w_p_tag == BB_TAG_BD);
      if (w_p_valid && (w_p_tag == BB_TAG_BUS)) begin
        r_dout <= w_p_data;
      end
      if (w_p_valid && (w_p_tag == BB_TAG_BD)) begin
        r_bd_rdata <= w_p_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_count <= '0;
      r_err_addr  <= '0;
    end else if (w_acc && !w_in_win) begin
      r_err_addr <= w_req.addr;
      if (r_err_count != 16'hFFFF) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign bb.bb_ext_dout_o = r_dout;
  assign bb.bd_rdata      = r_bd_rdata;
  assign bb.bd_rvalid     = r_bd_rvalid;
  assign bb.err_count     = r_err_count;
  assign bb.err_addr      = r_err_addr;

endmodule
